// File: rtl/i281_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i281_exec_sequencer
// Purpose  : Run / single-step / program-load sequencer for the single-cycle
//            i281 CPU. Decides which cycles commit an instruction (cpu_en),
//            stops on breakpoint or halt opcode, and owns the instruction
//            memory write port so a program can be loaded while halted.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            run_sw, step_btn      - run level switch / step button (synced)
//            bkpt_en, bkpt_addr    - PC breakpoint
//            pc_in, halt_op        - current PC and halt-opcode decode flag
//            ld_mode, ld_valid,
//            ld_addr, ld_data      - program-load request and word stream
//            ld_ready              - load words are accepted
//            imem_we, imem_waddr,
//            imem_wdata            - instruction-memory write port
//            cpu_en                - one-cycle commit enable to datapath
//            halted, state         - status (00 HALT, 01 RUN, 10 STEP, 11 LOAD)
//            ld_count              - words written this load, saturating
// Revision : 1.0 - initial release
// ============================================================================
module i281_exec_sequencer #(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 16,
    parameter int SETTLE  = 4      // cycles per instruction, 1..15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic               bkpt_en,
    input  logic [PC_W-1:0]    bkpt_addr,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               halt_op,
    input  logic               ld_mode,
    input  logic               ld_valid,
    input  logic [PC_W-1:0]    ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               ld_ready,
    output logic               imem_we,
    output logic [PC_W-1:0]    imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_en,
    output logic               halted,
    output logic [1:0]         state,
    output logic [PC_W:0]      ld_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_LOAD = 2'b11
    } state_t;

    localparam logic [3:0]    c_cnt_last = 4'(SETTLE - 1);
    localparam logic [PC_W:0] c_ld_max   = {1'b1, {PC_W{1'b0}}};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;
    logic                 r_skip;
    logic                 w_skip_nxt;
    logic                 r_run_q;
    logic                 r_step_q;
    logic                 r_cpu_en;
    logic                 w_cpu_en_nxt;
    logic                 r_halted;
    logic                 r_ld_ready;
    logic                 r_imem_we;
    logic [PC_W-1:0]      r_imem_waddr;
    logic [INSTR_W-1:0]   r_imem_wdata;
    logic [PC_W:0]        r_ld_count;
    logic                 w_ld_clear;

    logic w_run_rise;
    logic w_step_rise;
    logic w_commit_pt;
    logic w_bkpt_hit;
    logic w_xfer;

    assign w_run_rise  = run_sw & ~r_run_q;
    assign w_step_rise = step_btn & ~r_step_q;
    assign w_commit_pt = (r_cnt == c_cnt_last);
    // The skip flag lets a run started at the breakpoint PC get past it once.
    assign w_bkpt_hit  = bkpt_en & (pc_in == bkpt_addr) & ~r_skip;
    // ld_ready is only ever high in LOAD, so it alone qualifies a transfer;
    // a word accepted in the cycle ld_mode drops is still written.
    assign w_xfer      = ld_valid & r_ld_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and commit decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = 4'd0;
        w_skip_nxt   = r_skip;
        w_cpu_en_nxt = 1'b0;
        w_ld_clear   = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (ld_mode) begin
                    w_state_nxt = ST_LOAD;
                    w_ld_clear  = 1'b1;
                end else if (w_run_rise) begin
                    w_state_nxt = ST_RUN;
                    w_skip_nxt  = 1'b1;
                end else if (w_step_rise && !run_sw) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                // Dropping the switch abandons the partial instruction.
                if (!run_sw) begin
                    w_state_nxt = ST_HALT;
                end else if (w_commit_pt) begin
                    if (halt_op || w_bkpt_hit) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_cpu_en_nxt = 1'b1;
                        w_skip_nxt   = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_STEP: begin
                if (w_commit_pt) begin
                    w_cpu_en_nxt = ~halt_op;
                    w_state_nxt  = ST_HALT;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_LOAD: begin
                if (!ld_mode) begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, edge detectors, registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 4'd0;
            r_skip       <= 1'b0;
            r_run_q      <= 1'b0;
            r_step_q     <= 1'b0;
            r_cpu_en     <= 1'b0;
            r_halted     <= 1'b1;
            r_ld_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_ld_count   <= '0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_skip     <= w_skip_nxt;
            r_run_q    <= run_sw;
            r_step_q   <= step_btn;
            r_cpu_en   <= w_cpu_en_nxt;
            r_halted   <= (w_state_nxt == ST_HALT);
            r_ld_ready <= (w_state_nxt == ST_LOAD);
            r_imem_we  <= w_xfer;
            if (w_xfer) begin
                r_imem_waddr <= ld_addr;
                r_imem_wdata <= ld_data;
            end
            if (w_ld_clear) begin
                r_ld_count <= '0;
            end else if (w_xfer && (r_ld_count != c_ld_max)) begin
                r_ld_count <= r_ld_count + 1'b1;
            end
        end
    end

    assign ld_ready   = r_ld_ready;
    assign imem_we    = r_imem_we;
    assign imem_waddr = r_imem_waddr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_en     = r_cpu_en;
    assign halted     = r_halted;
    assign state      = r_state;
    assign ld_count   = r_ld_count;

endmodule
`default_nettype wire

// File: tb/tb_i281_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i281_exec_sequencer
// Purpose  : Self-checking bench for i281_exec_sequencer. A cycle-by-cycle
//            vector table covers run, breakpoint, step and halt-opcode
//            behaviour; hand sequences cover program load, asynchronous
//            reset during load, and a SETTLE=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i281_exec_sequencer;

    localparam logic [1:0] c_halt = 2'b00;
    localparam logic [1:0] c_run  = 2'b01;
    localparam logic [1:0] c_step = 2'b10;
    localparam logic [1:0] c_load = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_sw, step_btn, bkpt_en, halt_op;
    logic [4:0]  bkpt_addr, pc_in;
    logic        ld_mode, ld_valid;
    logic [4:0]  ld_addr;
    logic [15:0] ld_data;

    logic        ld_ready, imem_we, cpu_en, halted;
    logic [4:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic [1:0]  state;
    logic [5:0]  ld_count;

    logic        ld_ready_1, imem_we_1, cpu_en_1, halted_1;
    logic [4:0]  imem_waddr_1;
    logic [15:0] imem_wdata_1;
    logic [1:0]  state_1;
    logic [5:0]  ld_count_1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i281_exec_sequencer #(.PC_W(5), .INSTR_W(16), .SETTLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn),
        .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .pc_in(pc_in),
        .halt_op(halt_op), .ld_mode(ld_mode), .ld_valid(ld_valid),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_en(cpu_en), .halted(halted), .state(state), .ld_count(ld_count)
    );

    i281_exec_sequencer #(.PC_W(5), .INSTR_W(16), .SETTLE(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn),
        .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .pc_in(pc_in),
        .halt_op(halt_op), .ld_mode(ld_mode), .ld_valid(ld_valid),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready_1),
        .imem_we(imem_we_1), .imem_waddr(imem_waddr_1),
        .imem_wdata(imem_wdata_1), .cpu_en(cpu_en_1), .halted(halted_1),
        .state(state_1), .ld_count(ld_count_1)
    );

    typedef struct {
        logic       run;
        logic       step;
        logic       bken;
        logic [4:0] bka;
        logic [4:0] pc;
        logic       hop;
        logic       exp_cpu;
        logic [1:0] exp_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic run, input logic step,
                       input logic bken, input logic [4:0] bka,
                       input logic [4:0] pc, input logic hop,
                       input logic cpu, input logic [1:0] st);
        vec_t v;
        v.run = run; v.step = step; v.bken = bken; v.bka = bka;
        v.pc = pc; v.hop = hop; v.exp_cpu = cpu; v.exp_st = st;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run_sw = 0; step_btn = 0; bkpt_en = 0; halt_op = 0;
        bkpt_addr = 0; pc_in = 0; ld_mode = 0; ld_valid = 0;
        ld_addr = 0; ld_data = 0;

        // ---------------- vector table (one row per clock) -------------
        // run  step bken bka pc hop | cpu state
        // Run: commit every 4th cycle, drop run_sw mid-instruction.
        add(1, 1,0,0,0,0,0, 0,c_run);
        add(3, 1,0,0,0,0,0, 0,c_run);
        add(1, 1,0,0,0,0,0, 1,c_run);
        add(3, 1,0,0,0,0,0, 0,c_run);
        add(1, 1,0,0,0,0,0, 1,c_run);
        add(2, 1,0,0,0,0,0, 0,c_run);
        add(2, 0,0,0,0,0,0, 0,c_halt);
        // Breakpoint at PC 5, then skip past it on a fresh run edge.
        add(4, 1,0,1,5,3,0, 0,c_run);
        add(1, 1,0,1,5,3,0, 1,c_run);
        add(1, 1,0,1,5,3,0, 0,c_run);
        add(2, 1,0,1,5,4,0, 0,c_run);
        add(1, 1,0,1,5,4,0, 1,c_run);
        add(1, 1,0,1,5,4,0, 0,c_run);
        add(2, 1,0,1,5,5,0, 0,c_run);
        add(1, 1,0,1,5,5,0, 0,c_halt);
        add(1, 1,0,1,5,5,0, 0,c_halt);   // held switch: no restart
        add(1, 0,0,1,5,5,0, 0,c_halt);
        add(4, 1,0,1,5,5,0, 0,c_run);
        add(1, 1,0,1,5,5,0, 1,c_run);    // skip lets PC 5 commit
        add(1, 1,0,1,5,5,0, 0,c_run);
        add(2, 1,0,1,5,6,0, 0,c_run);
        add(1, 1,0,1,5,6,0, 1,c_run);
        add(1, 0,0,1,5,6,0, 0,c_halt);
        // Single step, breakpoint ignored, held button gives one step only.
        add(2, 0,1,1,5,5,0, 0,c_step);
        add(2, 0,0,1,5,5,0, 0,c_step);
        add(1, 0,0,1,5,5,0, 1,c_halt);
        add(1, 0,0,1,5,5,0, 0,c_halt);
        add(4, 0,1,1,5,5,0, 0,c_step);
        add(1, 0,1,1,5,5,0, 1,c_halt);
        add(2, 0,1,1,5,5,0, 0,c_halt);
        // Halt opcode: no commit, and re-running halts again.
        add(1, 0,0,0,0,7,0, 0,c_halt);
        add(4, 1,0,0,0,7,1, 0,c_run);
        add(1, 1,0,0,0,7,1, 0,c_halt);
        add(1, 0,0,0,0,7,1, 0,c_halt);
        add(4, 1,0,0,0,7,1, 0,c_run);
        add(1, 1,0,0,0,7,1, 0,c_halt);
        add(1, 0,0,0,0,7,0, 0,c_halt);

        // ---------------- reset state ----------------------------------
        tick(); tick();
        chk("rst_state",   32'(state), 32'(c_halt));
        chk("rst_halted",  32'(halted), 32'd1);
        chk("rst_cpu_en",  32'(cpu_en), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_ld_ready",32'(ld_ready), 32'd0);
        chk("rst_ld_count",32'(ld_count), 32'd0);
        chk("rst_waddr",   32'(imem_waddr), 32'd0);
        chk("rst_wdata",   32'(imem_wdata), 32'd0);
        rst_n = 1'b1;

        // ---------------- apply table ----------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            run_sw = vecs[i].run;   step_btn  = vecs[i].step;
            bkpt_en = vecs[i].bken; bkpt_addr = vecs[i].bka;
            pc_in = vecs[i].pc;     halt_op   = vecs[i].hop;
            tick();
            chk($sformatf("row%0d_cpu_en", i), 32'(cpu_en), 32'(vecs[i].exp_cpu));
            chk($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].exp_st));
            chk($sformatf("row%0d_halted", i), 32'(halted),
                32'(vecs[i].exp_st == c_halt));
            chk($sformatf("row%0d_imem_we", i), 32'(imem_we), 32'd0);
        end

        // ---------------- program load ---------------------------------
        ld_mode = 1'b1;
        tick();
        chk("ld_entry_state", 32'(state), 32'(c_load));
        chk("ld_entry_ready", 32'(ld_ready), 32'd1);
        chk("ld_entry_we",    32'(imem_we), 32'd0);
        chk("ld_entry_count", 32'(ld_count), 32'd0);
        begin
            logic [15:0] words [3];
            words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0F0F;
            for (int w = 0; w < 3; w++) begin
                ld_valid = 1'b1; ld_addr = 5'(w); ld_data = words[w];
                tick();
                chk($sformatf("ld%0d_we", w), 32'(imem_we), 32'd1);
                chk($sformatf("ld%0d_addr", w), 32'(imem_waddr), 32'(w));
                chk($sformatf("ld%0d_data", w), 32'(imem_wdata), 32'(words[w]));
                chk($sformatf("ld%0d_count", w), 32'(ld_count), 32'(w + 1));
                chk($sformatf("ld%0d_cpu_en", w), 32'(cpu_en), 32'd0);
            end
        end
        // Drop ld_mode with a fourth word still valid: it is still written.
        ld_mode = 1'b0; ld_addr = 5'd3; ld_data = 16'h5555;
        tick();
        chk("ld_exit_we",    32'(imem_we), 32'd1);
        chk("ld_exit_addr",  32'(imem_waddr), 32'd3);
        chk("ld_exit_data",  32'(imem_wdata), 32'h5555);
        chk("ld_exit_count", 32'(ld_count), 32'd4);
        chk("ld_exit_state", 32'(state), 32'(c_halt));
        chk("ld_exit_ready", 32'(ld_ready), 32'd0);
        tick();
        chk("ld_after_we",   32'(imem_we), 32'd0);
        ld_valid = 1'b0;
        tick();
        chk("ld_idle_we",    32'(imem_we), 32'd0);

        // ---------------- asynchronous reset during load ---------------
        ld_mode = 1'b1;
        tick();
        chk("ar_state_load", 32'(state), 32'(c_load));
        ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 16'hBEEF;
        tick();
        chk("ar_we_before", 32'(imem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_we",     32'(imem_we), 32'd0);
        chk("ar_ready",  32'(ld_ready), 32'd0);
        chk("ar_state",  32'(state), 32'(c_halt));
        chk("ar_halted", 32'(halted), 32'd1);
        chk("ar_count",  32'(ld_count), 32'd0);
        ld_mode = 1'b0; ld_valid = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        chk("ar_post_we", 32'(imem_we), 32'd0);

        // ---------------- SETTLE=1 vs SETTLE=4 from reset --------------
        run_sw = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("s1_cyc%0d_cpu_en", c), 32'(cpu_en_1), 32'(c >= 2));
            chk($sformatf("s4_cyc%0d_cpu_en", c), 32'(cpu_en), 32'(c == 5));
        end
        run_sw = 1'b0;
        tick();
        chk("s1_stop_state", 32'(state_1), 32'(c_halt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i281_exec_sequencer.md
Name: i281_exec_sequencer

Overview:
- Run/step/load sequencer for the single-cycle i281 CPU.
- Decides the cycles in which the CPU commits an instruction. `cpu_en` gates PC, register-file, flag and data-memory writes.
- Supports halt, single-step, breakpoint on PC, and halt-opcode stop.
- Owns the instruction-memory write port, so a program can be loaded while the CPU is halted.

Parameters:
- PC_W, 5, PC / instruction-memory address width.
- INSTR_W, 16, instruction word width.
- SETTLE, 4, clock cycles per instruction (settle time of the combinational decode/datapath); legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run_sw  in  1  run switch, level, already synchronised.
- step_btn  in  1  step button, already debounced/synchronised, level.
- bkpt_en  in  1  breakpoint enable.
- bkpt_addr  in  PC_W  breakpoint PC.
- pc_in  in  PC_W  current PC from datapath.
- halt_op  in  1  decoder flag: current instruction is the halt opcode.
- ld_mode  in  1  program-load request.
- ld_valid  in  1  load word valid.
- ld_addr  in  PC_W  load word address.
- ld_data  in  INSTR_W  load word.
- ld_ready  out  1  sequencer accepts load words.
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  PC_W  write address.
- imem_wdata  out  INSTR_W  write data.
- cpu_en  out  1  one-cycle commit enable to datapath.
- halted  out  1  high in HALT state.
- state  out  2  00 HALT, 01 RUN, 10 STEP, 11 LOAD.
- ld_count  out  PC_W+1  words written since entering LOAD, saturating at 2^PC_W.

Behaviour:
- Reset:
  - state HALT, halted 1.
  - cpu_en, imem_we, ld_ready 0; imem_waddr/wdata 0; ld_count 0.
  - Settle counter 0; skip flag 0; edge-detect registers 0.
  - Reset mid-load aborts immediately; no write is issued.
- All outputs are registered.
- run_sw and step_btn rising edges are detected internally (one-cycle registered compare).
- Settle counter runs in RUN/STEP only, counting 0..SETTLE-1. The cycle where count==SETTLE-1 is the commit point:
  - cpu_en is high for the following cycle, unless suppressed;
  - the counter returns to 0.
  - Entering RUN/STEP always starts the counter from 0.
  - SETTLE=1 gives a commit every cycle in RUN.
- HALT, priority order:
  - ld_mode high -> LOAD; ld_count cleared.
  - Else run_sw rising edge -> RUN; skip flag set.
  - Else step_btn rising edge with run_sw low -> STEP.
  - Holding run_sw high does not restart after a breakpoint or halt; a new rising edge is required.
- RUN:
  - run_sw low in any cycle -> HALT next cycle. Counter cleared; no commit issued for the partial instruction.
  - At the commit point, if halt_op=1 -> commit suppressed, HALT.
  - Else if bkpt_en=1, pc_in==bkpt_addr and skip=0 -> commit suppressed, HALT.
  - Otherwise commit is issued and skip is cleared.
  - ld_mode and step_btn are ignored.
- STEP:
  - Exactly one commit point, then HALT.
  - Breakpoint is ignored; halt_op still suppresses the commit.
- Halt opcode is terminal: RUN/STEP from that PC re-halts with no commit. Recovery is by reset or by reloading memory.
- LOAD:
  - ld_ready=1 in the cycle after entry, and continuously while in LOAD.
  - Transfer occurs when ld_valid & ld_ready. The next cycle has imem_we=1 with the registered ld_addr/ld_data, and ld_count increments (saturating).
  - Back-to-back transfers give back-to-back writes, one per cycle.
  - ld_mode low -> HALT and ld_ready drops the next cycle. A transfer accepted in the same cycle still produces its write.
  - imem_we is never asserted outside LOAD or that trailing cycle.
  - cpu_en is 0 throughout LOAD.
- cpu_en and imem_we are never high in the same cycle.

Test Plan:
1. Reset, SETTLE=4, raise run_sw -> state=01 and cpu_en pulses every 4th cycle. Drop run_sw mid-count -> HALT next cycle with no extra pulse.
2. bkpt_en=1, bkpt_addr=5, pc_in stepping 3,4,5 -> commits at PC 3 and 4, suppressed at 5, halted=1. Toggle run_sw 0->1 -> commit at PC 5 proceeds (skip flag), run continues.
3. From HALT, two step_btn pulses -> exactly one cpu_en pulse per press, state 10 then 00. Holding step_btn high -> no further pulses.
4. halt_op=1 at commit point in RUN -> no cpu_en, HALT. Re-run -> HALT again with no commit.
5. ld_mode=1, then 3 back-to-back words (addr 0,1,2; data 0x1234, 0xABCD, 0x0F0F) -> three consecutive imem_we cycles, each 1 cycle after acceptance, ld_count=3. Drop ld_mode with a 4th word valid -> 4th write still occurs, then HALT.
6. Assert rst_n low during LOAD with ld_valid high -> imem_we=0, ld_ready=0, state=00 immediately (asynchronous).
